// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter: serialises CPU MEM-stage and debug accesses onto one
// fixed-latency memory port, CPU first with a starvation guard for the debug port.
module dm_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic [STV_W-1:0]   starve_cnt, starve_cnt_nxt;
  logic               owner_dbg, owner_dbg_nxt;
  logic               grant_dbg;
  logic               cpu_done_nxt, dbg_done_nxt;
  logic [DATA_W-1:0]  cpu_rdata_nxt, dbg_rdata_nxt;
  logic               mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;

  assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

  // Next-state, arbitration and output computation
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    owner_dbg_nxt  = owner_dbg;
    grant_dbg      = 1'b0;
    cpu_done_nxt   = 1'b0;
    dbg_done_nxt   = 1'b0;
    cpu_rdata_nxt  = cpu_rdata_o;
    dbg_rdata_nxt  = dbg_rdata_o;
    mem_en_nxt     = mem_en_o;
    mem_we_nxt     = mem_we_o;
    mem_addr_nxt   = mem_addr_o;
    mem_wdata_nxt  = mem_wdata_o;

    case (state)
      IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          // Debug wins when alone or when the CPU has won STARVE_MAX contests in a row
          grant_dbg = dbg_req_i && (!cpu_req_i || (starve_cnt == STV_W'(STARVE_MAX)));
          if (grant_dbg) begin
            starve_cnt_nxt = '0;
          end else if (dbg_req_i) begin
            starve_cnt_nxt = (starve_cnt == {STV_W{1'b1}}) ? starve_cnt
                                                           : starve_cnt + STV_W'(1);
          end
          owner_dbg_nxt = grant_dbg;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = grant_dbg ? dbg_we_i : cpu_we_i;
          mem_addr_nxt  = (grant_dbg ? dbg_addr_i : cpu_addr_i) & ~ADDR_W'(3);
          mem_wdata_nxt = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          lat_cnt_nxt   = LAT_W'(MEM_LAT - 1);
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (lat_cnt == '0) begin
          if (!mem_we_o) begin
            if (owner_dbg) dbg_rdata_nxt = mem_rdata_i;
            else           cpu_rdata_nxt = mem_rdata_i;
          end
          if (owner_dbg) dbg_done_nxt = 1'b1;
          else           cpu_done_nxt = 1'b1;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          state_nxt  = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight access
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_dbg   <= 1'b0;
      cpu_done_o  <= 1'b0;
      dbg_done_o  <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      starve_cnt  <= starve_cnt_nxt;
      owner_dbg   <= owner_dbg_nxt;
      cpu_done_o  <= cpu_done_nxt;
      dbg_done_o  <= dbg_done_nxt;
      cpu_rdata_o <= cpu_rdata_nxt;
      dbg_rdata_o <= dbg_rdata_nxt;
      mem_en_o    <= mem_en_nxt;
      mem_we_o    <= mem_we_nxt;
      mem_addr_o  <= mem_addr_nxt;
      mem_wdata_o <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-timing model (grant rule, fixed latency, latched payload).
module tb_dm_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk_i, rst_n;
  logic        cpu_req_i, cpu_we_i, cpu_stall_o, cpu_done_o;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        dbg_req_i, dbg_we_i, dbg_done_o;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_stall_o(cpu_stall_o), .cpu_done_o(cpu_done_o),
    .cpu_rdata_o(cpu_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp, n_err;
  int cyc, free_edge, starve, g;
  logic have_tx, tx_dbg, tx_we;
  logic [31:0] tx_addr, tx_wdata, tx_rdata, exp_cpu_rdata, exp_dbg_rdata, force_rd;
  logic force_rd_en, rand_mode, scramble;
  int cpu_more, dbg_more;
  logic in_busy, cdone_exp, ddone_exp;
  int en_seen;
  logic [31:0] last_addr;
  bit done_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_cpu();
    cpu_we_i    = 1'($urandom_range(0, 1));
    cpu_addr_i  = 32'($urandom_range(0, 255));
    cpu_wdata_i = $urandom;
  endtask

  task automatic new_dbg();
    dbg_we_i    = 1'($urandom_range(0, 1));
    dbg_addr_i  = 32'($urandom_range(0, 255));
    dbg_wdata_i = $urandom;
  endtask

  // One clock: predict the grant at the coming edge, advance, check, then play the requesters
  task automatic step();
    logic gdbg;
    if (have_tx && cyc == g + LAT - 1) mem_rdata_i = tx_rdata;
    else                               mem_rdata_i = $urandom;
    if (cyc + 1 >= free_edge && (cpu_req_i || dbg_req_i)) begin
      gdbg = dbg_req_i && (!cpu_req_i || starve == SMAX);
      if (gdbg) starve = 0;
      else if (dbg_req_i && starve < 15) starve++;
      have_tx   = 1'b1;
      g         = cyc + 1;
      tx_dbg    = gdbg;
      tx_we     = gdbg ? dbg_we_i : cpu_we_i;
      tx_addr   = (gdbg ? dbg_addr_i : cpu_addr_i) & ~32'h3;
      tx_wdata  = gdbg ? dbg_wdata_i : cpu_wdata_i;
      tx_rdata  = force_rd_en ? force_rd : $urandom;
      free_edge = g + LAT + 2;
    end

    @(posedge clk_i);
    cyc++;
    #1;
    in_busy   = have_tx && cyc >= g && cyc < g + LAT;
    cdone_exp = have_tx && cyc == g + LAT && !tx_dbg;
    ddone_exp = have_tx && cyc == g + LAT && tx_dbg;
    if (cdone_exp && !tx_we) exp_cpu_rdata = tx_rdata;
    if (ddone_exp && !tx_we) exp_dbg_rdata = tx_rdata;

    chk("mem_en", 32'(mem_en_o), 32'(in_busy));
    if (in_busy) begin
      chk("mem_we", 32'(mem_we_o), 32'(tx_we));
      chk("mem_addr", mem_addr_o, tx_addr);
      chk("mem_wdata", mem_wdata_o, tx_wdata);
    end
    chk("cpu_done", 32'(cpu_done_o), 32'(cdone_exp));
    chk("dbg_done", 32'(dbg_done_o), 32'(ddone_exp));
    chk("cpu_rdata", cpu_rdata_o, exp_cpu_rdata);
    chk("dbg_rdata", dbg_rdata_o, exp_dbg_rdata);
    chk("cpu_stall", 32'(cpu_stall_o), 32'(cpu_req_i && !cdone_exp));
    if (mem_en_o === 1'b1) begin
      en_seen++;
      last_addr = mem_addr_o;
    end
    if (cpu_done_o === 1'b1) done_log.push_back(1'b0);
    if (dbg_done_o === 1'b1) done_log.push_back(1'b1);

    if (cdone_exp) begin
      if (cpu_more > 0) begin cpu_more--; new_cpu(); end
      else cpu_req_i = 1'b0;
    end
    if (ddone_exp) begin
      if (dbg_more > 0) begin dbg_more--; new_dbg(); end
      else dbg_req_i = 1'b0;
    end
    if (rand_mode) begin
      if (!cpu_req_i && $urandom_range(0, 3) != 0) begin cpu_req_i = 1'b1; new_cpu(); end
      if (!dbg_req_i && $urandom_range(0, 2) != 0) begin dbg_req_i = 1'b1; new_dbg(); end
    end
    // Owner inputs wander while it holds the port; only latched values may reach memory
    if (scramble && in_busy) begin
      if (tx_dbg) begin dbg_addr_i = $urandom; dbg_wdata_i = $urandom; dbg_we_i = ~dbg_we_i; end
      else        begin cpu_addr_i = $urandom; cpu_wdata_i = $urandom; cpu_we_i = ~cpu_we_i; end
    end
  endtask

  task automatic wait_done(input bit for_dbg, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      step();
      if ((for_dbg ? dbg_done_o : cpu_done_o) === 1'b1) at = cyc;
    end
    if (for_dbg) chk("dbg_done_timeout", 32'(at >= 0), 32'd1);
    else         chk("cpu_done_timeout", 32'(at >= 0), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (cpu_req_i || dbg_req_i); i++) step();
    chk("drain_timeout", 32'(cpu_req_i || dbg_req_i), 32'd0);
    step();
    step();
  endtask

  initial begin
    int c_at, d_at, at, start, base;
    logic [31:0] save;
    n_cmp = 0; n_err = 0; cyc = 0; free_edge = 0; starve = 0; g = 0;
    have_tx = 1'b0; tx_dbg = 1'b0; tx_we = 1'b0;
    tx_addr = '0; tx_wdata = '0; tx_rdata = '0;
    exp_cpu_rdata = '0; exp_dbg_rdata = '0; force_rd = '0;
    force_rd_en = 1'b0; rand_mode = 1'b0; scramble = 1'b0;
    cpu_more = 0; dbg_more = 0; en_seen = 0; last_addr = '0;
    rst_n = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    mem_rdata_i = '0;

    // Reset values
    #1;
    chk("rst_cpu_done", 32'(cpu_done_o), 32'd0);
    chk("rst_dbg_done", 32'(dbg_done_o), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata_o, 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    repeat (2) begin @(posedge clk_i); cyc++; end
    #1;
    rst_n = 1'b1;

    // CPU read of 0x10 returning 0xCAFE, address wandering during BUSY
    scramble = 1'b1; force_rd_en = 1'b1; force_rd = 32'hCAFE; en_seen = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; cpu_wdata_i = 32'h0;
    start = cyc;
    wait_done(1'b0, 20, at);
    chk("cpu_rd_data", cpu_rdata_o, 32'hCAFE);
    chk("cpu_rd_latency", 32'(at - start), 32'(LAT + 1));
    chk("cpu_rd_en_cycles", 32'(en_seen), 32'(LAT));
    chk("cpu_rd_addr", last_addr, 32'h10);
    step();
    chk("cpu_stall_after", 32'(cpu_stall_o), 32'd0);
    force_rd_en = 1'b0;

    // Simultaneous requests with no starvation history: CPU then debug
    step();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h20;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h30;
    wait_done(1'b0, 20, c_at);
    wait_done(1'b1, 20, d_at);
    chk("dbg_follows_cpu", 32'(d_at - c_at), 32'(LAT + 2));
    drain();

    // Both held continuously: debug gets every (SMAX+1)th grant
    base = done_log.size();
    cpu_more = 9; dbg_more = 9;
    cpu_req_i = 1'b1; new_cpu();
    dbg_req_i = 1'b1; new_dbg();
    for (int i = 0; i < 400 && done_log.size() < base + 10; i++) step();
    chk("starve_timeout", 32'(done_log.size() >= base + 10), 32'd1);
    for (int i = 0; i < 10; i++)
      if (base + i < done_log.size())
        chk("grant_order", 32'(done_log[base + i]), 32'((i == SMAX) || (i == 2 * SMAX + 1)));
    cpu_more = 0; dbg_more = 0;
    drain();

    // Debug write to unaligned 0x07: word-aligned address, rdata untouched
    save = exp_dbg_rdata; en_seen = 0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h07; dbg_wdata_i = 32'h55;
    wait_done(1'b1, 20, at);
    chk("dbg_wr_rdata_hold", dbg_rdata_o, save);
    chk("dbg_wr_addr", last_addr, 32'h04);
    chk("dbg_wr_en_cycles", 32'(en_seen), 32'(LAT));
    drain();

    // Asynchronous reset in the middle of a CPU access
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_more = 0;
    for (int i = 0; i < 10 && !in_busy; i++) step();
    chk("pre_rst_busy", 32'(mem_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_en", 32'(mem_en_o), 32'd0);
    chk("arst_cpu_done", 32'(cpu_done_o), 32'd0);
    chk("arst_dbg_done", 32'(dbg_done_o), 32'd0);
    chk("arst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("arst_dbg_rdata", dbg_rdata_o, 32'd0);
    have_tx = 1'b0; starve = 0; free_edge = 0;
    exp_cpu_rdata = '0; exp_dbg_rdata = '0;
    repeat (2) begin @(posedge clk_i); cyc++; end
    #1;
    rst_n = 1'b1;
    cpu_addr_i = 32'h44;
    start = cyc;
    wait_done(1'b0, 20, at);
    chk("rst_recover_lat", 32'(at - start), 32'(LAT + 1));
    drain();

    // Randomized traffic from both requesters
    rand_mode = 1'b1;
    for (int i = 0; i < 2500; i++) step();
    rand_mode = 1'b0; cpu_more = 0; dbg_more = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
